sdr_init_cmd_checker: RTL
=========================

Name: sdr_init_cmd_checker

Overview:
- Synthesizable protocol checker on the SDRAM side of the controller.
- Decodes the SDRAM command pins each sdram_clk cycle.
- Tracks the power-up initialization sequence: power-up NOP wait, PRECHARGE, auto-refreshes, LOAD MODE REGISTER, then sdr_init_done.
- After init, keeps policing refresh spacing. Reports a sticky first error with code and timestamp for the bench and scoreboard.

Parameters:
- CNT_W, 16: width of all cycle counters. Counters saturate at all-ones.
- T_PWRUP, 500: minimum NOP/deselect cycles after reset release before the first PRECHARGE.
- T_PWRUP_MAX, 2000: PRECHARGE must occur by this cycle count, else timeout.
- T_RP, 3: minimum cycles from PRECHARGE to the first AUTO_REFRESH.
- T_RFC, 8: minimum cycles between AUTO_REFRESHes, and from the last AUTO_REFRESH to LOAD MODE.
- N_REF, 2: minimum AUTO_REFRESH count before LOAD MODE.
- T_MRD_MAX, 16: maximum cycles from LOAD MODE to sdr_init_done rising.

Ports:
- sdram_clk  in  1  checker clock.
- sdram_resetn  in  1  synchronous, active-low reset.
- sdr_cke  in  1  SDRAM clock enable.
- sdr_cs_n  in  1  chip select.
- sdr_ras_n  in  1  RAS.
- sdr_cas_n  in  1  CAS.
- sdr_we_n  in  1  write enable.
- sdr_init_done  in  1  controller init-complete flag.
- init_ok  out  1  high in RUN state.
- init_err  out  1  sticky error flag.
- err_code  out  3  first error cause.
- err_time  out  CNT_W  cyc_cnt value at the first error.
- ref_count  out  CNT_W  total AUTO_REFRESH commands since reset, saturating.
- chk_state  out  3  current FSM state, for debug.

Behaviour:
- Interface: one clock, sdram_clk. Reset sdram_resetn is synchronous and active-low; it is sampled on the sdram_clk rising edge only.
- Reset values: init_ok=0, init_err=0, err_code=0, err_time=0, ref_count=0, chk_state=PWRUP. Internal cyc_cnt=0, gap_cnt=0, nref=0, done_d=0.
- cyc_cnt: 0 in the first cycle with sdram_resetn=1, +1 per cycle, saturating.
- Command decode, combinational, only when sdr_cke=1 and sdr_cs_n=0. {ras_n,cas_n,we_n}:
  - 111 NOP
  - 010 PRE
  - 001 REF
  - 000 LMR
  - anything else is OTHER (ACT/RD/WR/BST).
- cs_n=1 or cke=0 decodes as NOP.
- All outputs are registered and reflect the sampled cycle one edge later.
- gap_cnt: cleared to 0 on PRE/REF/LMR, otherwise +1, saturating. A command sampled at gap_cnt=g is g+1 cycles after the previous one.
- ref_count increments on every REF in any state except ERR.
- FSM states (chk_state encoding): PWRUP=0, PRE_DONE=1, REFRESH=2, WAIT_DONE=3, RUN=4, ERR=7.
- PWRUP:
  - Non-NOP other than PRE → ERR, code 1.
  - PRE with cyc_cnt<T_PWRUP → ERR, code 1.
  - PRE with cyc_cnt≥T_PWRUP → PRE_DONE.
  - cyc_cnt reaches T_PWRUP_MAX with no PRE → ERR, code 5.
- PRE_DONE:
  - REF with gap_cnt+1≥T_RP → REFRESH, nref=1.
  - REF too early → ERR, code 3.
  - PRE, LMR or OTHER → ERR, code 2.
- REFRESH:
  - REF with gap_cnt+1≥T_RFC → nref+1.
  - REF too early → ERR, code 3.
  - LMR with nref≥N_REF and gap_cnt+1≥T_RFC → WAIT_DONE.
  - LMR with nref<N_REF → ERR, code 4.
  - LMR with nref≥N_REF but too early → ERR, code 3.
  - PRE or OTHER → ERR, code 2.
- WAIT_DONE:
  - sdr_init_done=1 with gap_cnt+1≤T_MRD_MAX → RUN.
  - gap_cnt+1>T_MRD_MAX without done → ERR, code 5.
  - Any non-NOP → ERR, code 2.
- sdr_init_done=1 while in PWRUP, PRE_DONE or REFRESH → ERR, code 6. This takes priority over command checks in the same cycle.
- RUN:
  - init_ok=1.
  - REF with gap_cnt+1<T_RFC, measured from the previous REF or LMR → ERR, code 3.
  - sdr_init_done falling → ERR, code 7.
  - All other commands are legal.
- ERR: terminal until reset. init_err=1, init_ok=0. err_code and err_time hold the first violation; later violations are ignored. ref_count freezes.
- Reset mid-sequence: everything returns to reset values on the next edge, and checking restarts from PWRUP.

Test Plan:
1. Reset release; NOP ×505; PRE; NOP ×2; REF; NOP ×7; REF; NOP ×7; LMR; NOP ×8; sdr_init_done=1 → init_ok=1, chk_state=4, ref_count=2, init_err=0.
2. PRE at cyc_cnt=100 → init_err=1, err_code=1, err_time=100, chk_state=7. A later REF leaves ref_count=0 and err_code unchanged.
3. Nominal start, then the second REF 5 cycles after the first → err_code=3. Once in RUN, two REFs 4 cycles apart → err_code=3.
4. Nominal start with one REF, then LMR after 8 cycles → err_code=4. Variant: LMR, then no init_done for 17 cycles → err_code=5.
5. sdr_init_done pulsed during REFRESH → err_code=6. In RUN, drop sdr_init_done → err_code=7. ACT/RD/WR in RUN → no error.
6. Reset asserted in REFRESH with nref=1 → next cycle chk_state=0 and ref_count=0; a full nominal sequence then reaches init_ok=1.

Source files
------------

// File: rtl/sdr_init_cmd_checker.sv
// rtl/sdr_init_cmd_checker.sv - SDRAM power-up init sequence and refresh spacing checker
//
// Purpose: watches the SDRAM command pins and verifies the power-up sequence
//          (NOP wait, PRECHARGE, AUTO_REFRESHes, LOAD MODE, init done), then
//          keeps policing AUTO_REFRESH spacing. The first violation is latched
//          with a cause code and the cycle count at which it was seen.
// Ports:
//   sdram_clk      in   checker clock
//   sdram_resetn   in   synchronous active-low reset
//   sdr_cke        in   SDRAM clock enable
//   sdr_cs_n       in   chip select
//   sdr_ras_n      in   RAS
//   sdr_cas_n      in   CAS
//   sdr_we_n       in   write enable
//   sdr_init_done  in   controller init-complete flag
//   init_ok        out  high while in RUN
//   init_err       out  sticky error flag
//   err_code       out  first error cause
//   err_time       out  cycle count at the first error
//   ref_count      out  AUTO_REFRESH commands since reset (saturating)
//   chk_state      out  current FSM state

module sdr_init_cmd_checker #(
   parameter int CNT_W       = 16,
   parameter int T_PWRUP     = 500,
   parameter int T_PWRUP_MAX = 2000,
   parameter int T_RP        = 3,
   parameter int T_RFC       = 8,
   parameter int N_REF       = 2,
   parameter int T_MRD_MAX   = 16
) (
   input  logic             sdram_clk,
   input  logic             sdram_resetn,
   input  logic             sdr_cke,
   input  logic             sdr_cs_n,
   input  logic             sdr_ras_n,
   input  logic             sdr_cas_n,
   input  logic             sdr_we_n,
   input  logic             sdr_init_done,
   output logic             init_ok,
   output logic             init_err,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] err_time,
   output logic [CNT_W-1:0] ref_count,
   output logic [2:0]       chk_state
);

   typedef enum logic [2:0] {
      S_PWRUP     = 3'd0,
      S_PRE_DONE  = 3'd1,
      S_REFRESH   = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RUN       = 3'd4,
      S_ERR       = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_PRE   = 3'd1,
      CMD_REF   = 3'd2,
      CMD_LMR   = 3'd3,
      CMD_OTHER = 3'd4
   } cmd_e;

   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PWRUP_L     = CNT_W'(T_PWRUP);
   localparam logic [CNT_W-1:0] PWRUP_MAX_L = CNT_W'(T_PWRUP_MAX);
   localparam logic [CNT_W-1:0] NREF_L      = CNT_W'(N_REF);
   // Spacing thresholds are compared against gap+1, which needs one extra bit
   // so a saturated gap counter cannot wrap to zero.
   localparam logic [CNT_W:0]   RP_L        = (CNT_W+1)'(T_RP);
   localparam logic [CNT_W:0]   RFC_L       = (CNT_W+1)'(T_RFC);
   localparam logic [CNT_W:0]   MRD_L       = (CNT_W+1)'(T_MRD_MAX);
   localparam logic [CNT_W:0]   GAP_ONE     = {{CNT_W{1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
   endfunction

   state_e            state_q, state_d;
   cmd_e              cmd;
   logic [CNT_W-1:0]  cyc_cnt_q;
   logic [CNT_W-1:0]  gap_cnt_q;
   logic [CNT_W-1:0]  rgap_cnt_q;
   logic [CNT_W-1:0]  nref_q, nref_d;
   logic [CNT_W-1:0]  ref_count_q;
   logic [CNT_W-1:0]  err_time_q;
   logic [2:0]        err_code_q;
   logic [2:0]        code_d;
   logic              done_q;
   logic              init_ok_q;
   logic              init_err_q;
   logic [CNT_W:0]    gap_p1;
   logic [CNT_W:0]    rgap_p1;
   logic              is_ctl;
   logic              is_ref_lmr;

   // Command decode; a deselected or clock-disabled device sees a NOP.
   always_comb begin
      cmd = CMD_NOP;
      if (sdr_cke && !sdr_cs_n) begin
         case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
            3'b111:  cmd = CMD_NOP;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_LMR;
            default: cmd = CMD_OTHER;
         endcase
      end
   end

   assign is_ctl     = (cmd == CMD_PRE) || (cmd == CMD_REF) || (cmd == CMD_LMR);
   assign is_ref_lmr = (cmd == CMD_REF) || (cmd == CMD_LMR);

   // gap_cnt restarts on any PRE/REF/LMR and drives the init-phase spacing.
   // In RUN the controller issues PRECHARGE freely, so refresh spacing there
   // uses a separate counter that only restarts on REF/LMR.
   assign gap_p1  = {1'b0, gap_cnt_q} + GAP_ONE;
   assign rgap_p1 = {1'b0, rgap_cnt_q} + GAP_ONE;

   always_comb begin
      state_d = state_q;
      nref_d  = nref_q;
      code_d  = 3'd0;
      case (state_q)
         S_PWRUP: begin
            if (sdr_init_done) begin
               code_d = 3'd6;
            end else if (cmd == CMD_PRE) begin
               if (cyc_cnt_q >= PWRUP_L) state_d = S_PRE_DONE;
               else                      code_d  = 3'd1;
            end else if (cmd != CMD_NOP) begin
               code_d = 3'd1;
            end else if (cyc_cnt_q >= PWRUP_MAX_L) begin
               code_d = 3'd5;
            end
         end
         S_PRE_DONE: begin
            if (sdr_init_done) begin
               code_d = 3'd6;
            end else if (cmd == CMD_REF) begin
               if (gap_p1 >= RP_L) begin
                  state_d = S_REFRESH;
                  nref_d  = CNT_ONE;
               end else begin
                  code_d = 3'd3;
               end
            end else if (cmd != CMD_NOP) begin
               code_d = 3'd2;
            end
         end
         S_REFRESH: begin
            if (sdr_init_done) begin
               code_d = 3'd6;
            end else if (cmd == CMD_REF) begin
               if (gap_p1 >= RFC_L) nref_d = sat_inc(nref_q);
               else                 code_d = 3'd3;
            end else if (cmd == CMD_LMR) begin
               if (nref_q < NREF_L)      code_d  = 3'd4;
               else if (gap_p1 < RFC_L)  code_d  = 3'd3;
               else                      state_d = S_WAIT_DONE;
            end else if (cmd != CMD_NOP) begin
               code_d = 3'd2;
            end
         end
         S_WAIT_DONE: begin
            if (cmd != CMD_NOP) begin
               code_d = 3'd2;
            end else if (sdr_init_done && (gap_p1 <= MRD_L)) begin
               state_d = S_RUN;
            end else if (gap_p1 > MRD_L) begin
               code_d = 3'd5;
            end
         end
         S_RUN: begin
            if (done_q && !sdr_init_done) begin
               code_d = 3'd7;
            end else if ((cmd == CMD_REF) && (rgap_p1 < RFC_L)) begin
               code_d = 3'd3;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
      if (code_d != 3'd0) state_d = S_ERR;
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state_q     <= S_PWRUP;
         cyc_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         rgap_cnt_q  <= '0;
         nref_q      <= '0;
         ref_count_q <= '0;
         err_time_q  <= '0;
         err_code_q  <= 3'd0;
         done_q      <= 1'b0;
         init_ok_q   <= 1'b0;
         init_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_cnt_q  <= sat_inc(cyc_cnt_q);
         gap_cnt_q  <= is_ctl     ? '0 : sat_inc(gap_cnt_q);
         rgap_cnt_q <= is_ref_lmr ? '0 : sat_inc(rgap_cnt_q);
         nref_q     <= nref_d;
         done_q     <= sdr_init_done;
         init_ok_q  <= (state_d == S_RUN);
         init_err_q <= (state_d == S_ERR);
         if ((cmd == CMD_REF) && (state_q != S_ERR)) begin
            ref_count_q <= sat_inc(ref_count_q);
         end
         // code_d is only ever non-zero outside ERR, so this latches the first cause.
         if (code_d != 3'd0) begin
            err_code_q <= code_d;
            err_time_q <= cyc_cnt_q;
         end
      end
   end

   assign init_ok   = init_ok_q;
   assign init_err  = init_err_q;
   assign err_code  = err_code_q;
   assign err_time  = err_time_q;
   assign ref_count = ref_count_q;
   assign chk_state = state_q;

endmodule
